// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - registered NCH-way arbiter in front of a single memory port
// One requester owns the port per transaction; address/data are held until mem_ack_i.
module mem_port_arbiter #(
   parameter int WIDTH = 32,
   parameter int NCH   = 2,
   parameter int MODE  = 0
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic [NCH-1:0]       req_i,
   input  logic [NCH-1:0]       we_i,
   input  logic [NCH*WIDTH-1:0] addr_i,
   input  logic [NCH*WIDTH-1:0] wdata_i,
   output logic                 mem_req_o,
   output logic                 mem_we_o,
   output logic [WIDTH-1:0]     mem_addr_o,
   output logic [WIDTH-1:0]     mem_wdata_o,
   input  logic                 mem_ack_i,
   input  logic [WIDTH-1:0]     mem_rdata_i,
   output logic [NCH-1:0]       gnt_o,
   output logic [NCH-1:0]       done_o,
   output logic [WIDTH-1:0]     rdata_o,
   output logic                 busy_o
);

   localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

   state_e           state_q, state_d;
   logic             mem_req_q, mem_req_d;
   logic             mem_we_q, mem_we_d;
   logic             busy_q, busy_d;
   logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic [NCH-1:0]   gnt_q, gnt_d;
   logic [NCH-1:0]   done_q, done_d;
   logic [PW-1:0]    rr_q, rr_d;
   logic [PW-1:0]    own_q, own_d;
   logic [PW-1:0]    win;
   logic [NCH-1:0]   win_oh;

   // Search starts at rr_q in round-robin mode, at 0 for fixed priority; first active req wins.
   always_comb begin : arbitrate
      int             idx;
      logic           found;
      logic [NCH-1:0] mask;
      win   = '0;
      found = 1'b0;
      idx   = 0;
      mask  = '0;
      for (int k = 0; k < NCH; k++) begin
         idx = (MODE == 1) ? int'(rr_q) + k : k;
         if (idx >= NCH) idx = idx - NCH;
         mask = NCH'(1) << idx;
         if (!found && ((req_i & mask) != '0)) begin
            found = 1'b1;
            win   = PW'(idx);
         end
      end
      win_oh = NCH'(1) << win;
   end

   always_comb begin : fsm
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
      gnt_d       = gnt_q;
      done_d      = done_q;
      busy_d      = busy_q;
      rr_d        = rr_q;
      own_d       = own_q;
      case (state_q)
         IDLE: begin
            gnt_d     = '0;
            mem_req_d = 1'b0;
            if (req_i != '0) begin
               state_d     = BUSY;
               mem_req_d   = 1'b1;
               mem_we_d    = (we_i & win_oh) != '0;
               mem_addr_d  = WIDTH'(addr_i >> (int'(win) * WIDTH));
               mem_wdata_d = WIDTH'(wdata_i >> (int'(win) * WIDTH));
               gnt_d       = win_oh;
               own_d       = win;
               busy_d      = 1'b1;
            end
         end
         BUSY: begin
            if (mem_ack_i) begin
               state_d   = RESP;
               rdata_d   = mem_rdata_i;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               done_d    = gnt_q;
            end
         end
         RESP: begin
            state_d = IDLE;
            done_d  = '0;
            gnt_d   = '0;
            busy_d  = 1'b0;
            if (MODE == 1) begin
               rr_d = (int'(own_q) == NCH - 1) ? '0 : PW'(int'(own_q) + 1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
         gnt_q       <= '0;
         done_q      <= '0;
         busy_q      <= 1'b0;
         rr_q        <= '0;
         own_q       <= '0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
         gnt_q       <= gnt_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         rr_q        <= rr_d;
         own_q       <= own_d;
      end
   end

   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign gnt_o       = gnt_q;
   assign done_o      = done_q;
   assign rdata_o     = rdata_q;
   assign busy_o      = busy_q;

endmodule
